fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Parametrised successor to the core's single-register program counter. Generates sequential
//  fetch PCs and issues them to instruction memory over a valid/ready request channel.
//  Buffers in-order responses, tagged with their PC, in a DEPTH-entry FIFO for sdecode.
//  Accepts branch/jump redirects, flushes the buffer and discards stale in-flight responses.
// PARAMETERS
//  XLEN      32            address/PC width
//  RESET_PC  32'h0000_0000 first fetch address after reset (bits [1:0] must be 0)
//  DEPTH     4             instruction FIFO entries; power of 2, >=2; also caps in-flight requests
// PORTS
//  clk              in   1              single clock, rising edge
//  rst              in   1              reset; synchronous, active-high
//  imem_req_valid_o out  1              fetch request valid
//  imem_req_ready_i in   1              imem accepts request
//  imem_req_addr_o  out  XLEN           fetch address (= pc_q)
//  imem_rsp_valid_i in   1              response valid (in order, >=1 cycle after accept)
//  imem_rsp_data_i  in   32             instruction word
//  redirect_i       in   1              taken branch/jump
//  redirect_pc_i    in   XLEN           redirect target
//  instr_valid_o    out  1              FIFO head valid
//  instr_ready_i    in   1              decode consumes head
//  instr_o          out  32             head instruction
//  instr_pc_o       out  XLEN           head PC
//  count_o          out  $clog2(DEPTH)+1  FIFO occupancy
// BEHAVIOUR
//  Interface: one clock; reset is synchronous and active-high.
//  Reset: state=IDLE, pc_q=RESET_PC, rsp_pc=RESET_PC, occupancy/outstanding/drop=0.
//   All outputs are 0; addr_o=RESET_PC. Reset mid-operation discards everything; no stale data survives.
//  States:
//   IDLE: one cycle after reset, -> FETCH.
//   FETCH: normal operation.
//   FLUSH: drop>0; stale responses are discarded; -> FETCH when drop reaches 0.
//   Redirect in any non-IDLE state -> FLUSH if stale>0, else FETCH.
//  Request:
//   imem_req_valid_o = (state!=IDLE) & !redirect_i & (count + outstanding < DEPTH). Combinational.
//   Valid may drop without a handshake; imem tolerates this.
//   On accept (valid&ready): pc_q += 4, outstanding += 1.
//   Requests continue to issue in FLUSH.
//  Response:
//   imem_rsp_valid_i decrements outstanding. Ignored if outstanding==0 (protocol error).
//   If drop>0: response discarded, drop -= 1.
//   Else: {data, rsp_pc} written to FIFO, rsp_pc += 4. Visible on instr_valid_o the next cycle.
//  Output: instr_valid_o = count!=0. instr_o/instr_pc_o show the head entry and read 0 when empty.
//   Pop on valid&ready. Push and pop may occur in the same cycle; count is unchanged.
//   Credit rule guarantees no overflow.
//  Redirect at cycle T (highest priority):
//   Alignment: target = {redirect_pc_i[XLEN-1:2],2'b00}.
//   Buffer: FIFO flushed (count=0 at T+1); a same-cycle pop or push is ignored.
//   Stale count: stale = outstanding - (rsp_valid at T); drop=stale.
//   PCs: pc_q=rsp_pc=target.
//   Timing: no request at T; first request for target at T+1.
//  Width: PC arithmetic is modulo 2^XLEN; 0xFFFF_FFFC+4 wraps to 0.
// TESTING
//  1 rst 1->0, imem ready, 1-cycle rsp -> IDLE 1 cycle, addrs 0x0,0x4,0x8...; instr_pc_o follows 0x0,0x4 in order.
//  2 DEPTH=4, instr_ready_i=0 -> exactly 4 accepts then req_valid=0, count_o=4; one pop -> one new request.
//  3 2 in flight, redirect to 0x100 -> next addr 0x100, 2 rsps dropped, first instr_pc_o=0x100.
//  4 Redirect same cycle as pop + rsp -> no request, count_o=0 next cycle, rsp dropped, drop=outstanding-1.
//  5 redirect_pc_i=0x103 -> imem_req_addr_o=0x100; pc_q=0xFFFF_FFFC accepted -> next addr 0x0.
//  6 rst during FLUSH with drop=3 -> IDLE, addr=RESET_PC, count_o=0; post-reset responses accepted, not dropped.

Source files
------------

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - sequential PC fetch with in-order response FIFO and redirect flush
module fetch_unit #(
   parameter int unsigned XLEN = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   output logic                     imem_req_valid_o,
   input  logic                     imem_req_ready_i,
   output logic [XLEN-1:0]          imem_req_addr_o,
   input  logic                     imem_rsp_valid_i,
   input  logic [31:0]              imem_rsp_data_i,
   input  logic                     redirect_i,
   input  logic [XLEN-1:0]          redirect_pc_i,
   output logic                     instr_valid_o,
   input  logic                     instr_ready_i,
   output logic [31:0]              instr_o,
   output logic [XLEN-1:0]          instr_pc_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      FLUSH = 2'd2
   } state_t;

   state_t state;

   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] rsp_pc;
   logic [CW-1:0]   count;
   logic [CW-1:0]   outstanding;
   logic [CW-1:0]   drop;
   logic [AW-1:0]   rd_ptr;
   logic [AW-1:0]   wr_ptr;

   logic [31:0]     fifo_data [DEPTH];
   logic [XLEN-1:0] fifo_pc   [DEPTH];

   logic            active;
   logic            redirect;
   logic            accept;
   logic            rsp_take;
   logic            rsp_drop;
   logic            push;
   logic            pop;
   logic [CW:0]     in_use;
   logic [CW-1:0]   stale;
   logic [CW-1:0]   outstanding_next;
   logic [CW-1:0]   drop_next;
   logic [XLEN-1:0] target;

   // The low two target bits are forced to zero by alignment, so they are never read.
   logic unused_pc_bits;
   assign unused_pc_bits = ^redirect_pc_i[1:0];

   // Request credit, response filtering, FIFO push/pop qualification and redirect bookkeeping.
   always_comb begin
      active           = (state != IDLE);
      redirect         = active && redirect_i;
      // FIFO slots are reserved for every in-flight request so a response can never overflow.
      in_use           = {1'b0, count} + {1'b0, outstanding};
      imem_req_valid_o = active && !redirect_i && (in_use < DEPTH_W);
      accept           = imem_req_valid_o && imem_req_ready_i;
      // A response with nothing outstanding is a protocol error and is ignored entirely.
      rsp_take         = imem_rsp_valid_i && (outstanding != '0);
      rsp_drop         = rsp_take && (drop != '0);
      push             = rsp_take && !rsp_drop && !redirect;
      pop              = (count != '0) && instr_ready_i && !redirect;
      // A response arriving in the redirect cycle itself is already gone; only the rest are stale.
      stale            = outstanding - CW'(rsp_take);
      outstanding_next = outstanding + CW'(accept) - CW'(rsp_take);
      target           = {redirect_pc_i[XLEN-1:2], 2'b00};
      if (redirect) begin
         drop_next = stale;
      end else if (rsp_drop) begin
         drop_next = drop - CW'(1);
      end else begin
         drop_next = drop;
      end
   end

   // Control FSM: IDLE for one cycle after reset, then FETCH/FLUSH tracking the drop counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         pc_q        <= RESET_PC;
         rsp_pc      <= RESET_PC;
         outstanding <= '0;
         drop        <= '0;
      end else begin
         outstanding <= outstanding_next;
         drop        <= drop_next;
         case (state)
            IDLE: begin
               state <= FETCH;
            end
            default: begin
               state <= (drop_next != '0) ? FLUSH : FETCH;
               if (redirect) begin
                  pc_q   <= target;
                  rsp_pc <= target;
               end else begin
                  if (accept) begin
                     pc_q <= pc_q + XLEN'(4);
                  end
                  if (push) begin
                     rsp_pc <= rsp_pc + XLEN'(4);
                  end
               end
            end
         endcase
      end
   end

   // FIFO pointers and occupancy; a redirect empties the buffer and overrides same-cycle push/pop.
   always_ff @(posedge clk) begin
      if (rst || redirect) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count + CW'(push) - CW'(pop);
      end
   end

   // FIFO storage; contents need no reset because empty entries are masked at the output.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_data[wr_ptr] <= imem_rsp_data_i;
         fifo_pc[wr_ptr]   <= rsp_pc;
      end
   end

   // Head-of-FIFO presentation; data and PC read as zero while the buffer is empty.
   always_comb begin
      imem_req_addr_o = pc_q;
      count_o         = count;
      instr_valid_o   = (count != '0);
      instr_o         = instr_valid_o ? fifo_data[rd_ptr] : '0;
      instr_pc_o      = instr_valid_o ? fifo_pc[rd_ptr] : '0;
   end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - fetch_unit bench with queue-based reference model and randomized imem/decode
module tb_fetch_unit;

   localparam int XLEN = 32;
   localparam int DEPTH = 4;
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic            clk = 1'b0;
   logic            rst;
   logic            imem_req_valid_o;
   logic            imem_req_ready_i;
   logic [31:0]     imem_req_addr_o;
   logic            imem_rsp_valid_i;
   logic [31:0]     imem_rsp_data_i;
   logic            redirect_i;
   logic [31:0]     redirect_pc_i;
   logic            instr_valid_o;
   logic            instr_ready_i;
   logic [31:0]     instr_o;
   logic [31:0]     instr_pc_o;
   logic [CW-1:0]   count_o;

   always #5 clk = ~clk;

   fetch_unit #(.XLEN(XLEN), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
      .clk              (clk),
      .rst              (rst),
      .imem_req_valid_o (imem_req_valid_o),
      .imem_req_ready_i (imem_req_ready_i),
      .imem_req_addr_o  (imem_req_addr_o),
      .imem_rsp_valid_i (imem_rsp_valid_i),
      .imem_rsp_data_i  (imem_rsp_data_i),
      .redirect_i       (redirect_i),
      .redirect_pc_i    (redirect_pc_i),
      .instr_valid_o    (instr_valid_o),
      .instr_ready_i    (instr_ready_i),
      .instr_o          (instr_o),
      .instr_pc_o       (instr_pc_o),
      .count_o          (count_o)
   );

   typedef struct { logic [31:0] addr; bit stale; } req_t;
   typedef struct { logic [31:0] data; logic [31:0] pc; } ent_t;

   // Reference model: requests in flight (oldest first) and the decode buffer contents.
   req_t        inflight[$];
   ent_t        fifo[$];
   bit          m_valid;
   bit          m_idle;
   logic [31:0] m_pc;

   int          n_vec;
   int          n_err;
   int          acc_cnt;
   logic        s_req_valid;
   logic [31:0] s_addr;
   logic [31:0] s_ipc;
   logic [CW-1:0] s_count;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock: drive inputs at the falling edge, compare 1ns later, advance model, wait a cycle.
   task automatic step(input bit r, input bit rd, input logic [31:0] rpc, input bit rdy,
                       input bit rspv, input bit irdy, input bit spur);
      bit          rv;
      bit          exp_rv;
      bit          acc;
      bit          got;
      req_t        rq;
      logic [31:0] exp_instr;
      logic [31:0] exp_ipc;
      rv  = (rspv && inflight.size() != 0) || spur;
      got = 1'b0;
      rst              = r;
      redirect_i       = rd;
      redirect_pc_i    = rpc;
      imem_req_ready_i = rdy;
      instr_ready_i    = irdy;
      imem_rsp_valid_i = rv;
      imem_rsp_data_i  = (inflight.size() != 0) ? mem_word(inflight[0].addr) : $urandom;
      #1;
      exp_rv    = !m_idle && !rd && (fifo.size() + inflight.size() < DEPTH);
      exp_instr = (fifo.size() != 0) ? fifo[0].data : 32'h0;
      exp_ipc   = (fifo.size() != 0) ? fifo[0].pc : 32'h0;
      s_req_valid = imem_req_valid_o;
      s_addr      = imem_req_addr_o;
      s_ipc       = instr_pc_o;
      s_count     = count_o;
      if (m_valid) begin
         check("req_valid", imem_req_valid_o, exp_rv);
         check("req_addr", imem_req_addr_o, m_pc);
         check("instr_valid", instr_valid_o, fifo.size() != 0);
         check("count", count_o, fifo.size());
         check("instr", instr_o, exp_instr);
         check("instr_pc", instr_pc_o, exp_ipc);
      end
      if (s_req_valid && rdy) acc_cnt++;
      acc = exp_rv && rdy;
      if (r) begin
         inflight.delete();
         fifo.delete();
         m_idle  = 1'b1;
         m_pc    = RESET_PC;
         m_valid = 1'b1;
      end else if (m_idle) begin
         m_idle = 1'b0;
      end else begin
         if (rv && inflight.size() != 0) begin
            rq  = inflight.pop_front();
            got = 1'b1;
         end
         if (rd) begin
            fifo.delete();
            foreach (inflight[i]) inflight[i].stale = 1'b1;
            m_pc = {rpc[31:2], 2'b00};
         end else begin
            if (irdy && fifo.size() != 0) void'(fifo.pop_front());
            if (got && !rq.stale) fifo.push_back('{mem_word(rq.addr), rq.addr});
            if (acc) begin
               inflight.push_back('{m_pc, 1'b0});
               m_pc = m_pc + 32'd4;
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic go(input bit rdy, input bit rspv, input bit irdy);
      step(1'b0, 1'b0, 32'h0, rdy, rspv, irdy, 1'b0);
   endtask

   bit          r_r;
   bit          r_rd;
   logic [31:0] r_pc;

   initial begin
      n_vec = 0; n_err = 0; acc_cnt = 0;
      m_valid = 1'b0; m_idle = 1'b1; m_pc = RESET_PC;
      rst = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0; imem_req_ready_i = 1'b0;
      imem_rsp_valid_i = 1'b0; imem_rsp_data_i = '0; instr_ready_i = 1'b0;
      @(negedge clk);

      // Sequential fetch after reset with a one-cycle imem
      step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0);
      go(1, 1, 1);
      check("t1_idle_req", s_req_valid, 1'b0);
      check("t1_idle_count", s_count, 0);
      go(1, 1, 1);
      check("t1_addr0", s_addr, 32'h0);
      check("t1_req0", s_req_valid, 1'b1);
      go(1, 1, 1);
      check("t1_addr1", s_addr, 32'h4);
      go(1, 1, 1);
      check("t1_addr2", s_addr, 32'h8);
      check("t1_ipc0", s_ipc, 32'h0);
      go(1, 1, 1);
      check("t1_addr3", s_addr, 32'hC);
      check("t1_ipc1", s_ipc, 32'h4);

      // Credit limit with decode stalled
      step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
      acc_cnt = 0;
      for (int i = 0; i < 10; i++) go(1, 1, 0);
      check("t2_accepts", acc_cnt, 4);
      check("t2_count_full", s_count, 4);
      check("t2_req_blocked", s_req_valid, 1'b0);
      go(1, 1, 1);
      acc_cnt = 0;
      for (int i = 0; i < 5; i++) go(1, 1, 0);
      check("t2_refill_accepts", acc_cnt, 1);
      check("t2_count_refull", s_count, 4);

      // Redirect with two requests in flight
      step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
      go(1, 0, 1);
      go(1, 0, 1);
      go(1, 0, 1);
      step(1'b0, 1'b1, 32'h100, 1'b1, 1'b0, 1'b1, 1'b0);
      check("t3_redir_noreq", s_req_valid, 1'b0);
      go(1, 1, 0);
      check("t3_target_addr", s_addr, 32'h100);
      check("t3_target_req", s_req_valid, 1'b1);
      for (int i = 0; i < 5; i++) go(1, 1, 0);
      check("t3_first_ipc", s_ipc, 32'h100);

      // Redirect coinciding with a pop and a response
      step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
      go(1, 1, 0);
      go(1, 1, 0);
      go(1, 1, 0);
      go(1, 0, 0);
      go(1, 0, 0);
      step(1'b0, 1'b1, 32'h200, 1'b1, 1'b1, 1'b1, 1'b0);
      check("t4_redir_noreq", s_req_valid, 1'b0);
      go(1, 1, 0);
      check("t4_flushed", s_count, 0);
      for (int i = 0; i < 4; i++) go(1, 1, 0);
      check("t4_first_ipc", s_ipc, 32'h200);

      // Target alignment and PC wraparound
      step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
      go(1, 0, 1);
      step(1'b0, 1'b1, 32'h103, 1'b1, 1'b0, 1'b1, 1'b0);
      go(1, 0, 1);
      check("t5_aligned", s_addr, 32'h100);
      step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b1, 1'b0);
      go(1, 1, 1);
      check("t5_top_addr", s_addr, 32'hFFFF_FFFC);
      go(1, 1, 1);
      check("t5_wrap_addr", s_addr, 32'h0);
      go(1, 1, 1);
      check("t5_top_ipc", s_ipc, 32'hFFFF_FFFC);

      // Reset while flushing three stale responses
      step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
      go(1, 0, 1);
      go(1, 0, 1);
      go(1, 0, 1);
      go(1, 0, 1);
      step(1'b0, 1'b1, 32'h300, 1'b1, 1'b0, 1'b1, 1'b0);
      go(1, 0, 1);
      step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
      go(1, 1, 0);
      check("t6_reset_addr", s_addr, RESET_PC);
      check("t6_reset_count", s_count, 0);
      check("t6_reset_req", s_req_valid, 1'b0);
      for (int i = 0; i < 4; i++) go(1, 1, 0);
      check("t6_post_count", s_count, 2);
      check("t6_post_ipc", s_ipc, 32'h0);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         r_r  = ($urandom_range(0, 199) == 0);
         r_rd = ($urandom_range(0, 15) == 0);
         r_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFE0 | 32'($urandom_range(0, 31))) : $urandom;
         step(r_r, r_rd, r_pc, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
              $urandom_range(0, 9) < 6, (inflight.size() == 0) && ($urandom_range(0, 29) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
